// File: rtl/line_mem_responder.sv
// Line-granular memory responder: one full-line read or write at a time, fixed LATENCY, one-cycle mem_resp.
// Define MEM_STATS_EN to add the rd_count/wr_count completion counters.
module line_mem_responder #(
  parameter int s_offset    = 5,
  parameter int s_line      = 8 * 2**s_offset,
  parameter int s_mem_index = 10,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [3:0]        mem_byte_enable,
  input  logic [s_line-1:0] mem_wdata,
  output logic [s_line-1:0] mem_rdata,
  output logic              mem_resp,
`ifdef MEM_STATS_EN
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
`endif
  output logic              protocol_err
);

  localparam int depth = 2**s_mem_index;
  localparam logic [7:0] lat_init = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state;
  logic [7:0]             count;
  logic                   op_write;
  logic [s_mem_index-1:0] idx;
  logic [s_line-1:0]      wdata_q;
  logic [s_line-1:0]      store [depth];

  logic [s_mem_index-1:0] req_idx;
  logic                   req_one;
  logic                   unused_bits;

  assign req_idx = mem_address[s_offset +: s_mem_index];
  assign req_one = mem_read ^ mem_write;
  assign unused_bits = ^{mem_byte_enable, mem_address[31:s_offset+s_mem_index],
                         mem_address[s_offset-1:0]};

  // Read data is fetched on the edge that enters RESP, so it is valid during the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      op_write     <= 1'b0;
      idx          <= '0;
      wdata_q      <= '0;
      mem_rdata    <= '0;
      mem_resp     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      mem_resp     <= 1'b0;
      protocol_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read && mem_write) begin
            protocol_err <= 1'b1;
          end else if (req_one) begin
            op_write <= mem_write;
            idx      <= req_idx;
            wdata_q  <= mem_wdata;
            count    <= lat_init;
            if (LATENCY > 1) begin
              state <= BUSY;
            end else begin
              state    <= RESP;
              mem_resp <= 1'b1;
              if (mem_read) mem_rdata <= store[req_idx];
            end
          end
        end
        BUSY: begin
          count <= count - 8'd1;
          if (count == 8'd1) begin
            state    <= RESP;
            mem_resp <= 1'b1;
            if (!op_write) mem_rdata <= store[idx];
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backing store is never cleared; a reset during RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && op_write) begin
      store[idx] <= wdata_q;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESP) begin
      if (op_write) wr_count <= wr_count + 32'd1;
      else          rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Line-granular main-memory responder; the device end of the cache's downstream mem_itf. It sits on the far side of the cache's ca_itf controller port.
- Accepts one full-line read or write at a time, waits a fixed programmable latency, then pulses mem_resp.
- Backs an internal line array. Serves as the memory model in the cache testbench and as the synthesizable stand-in for DRAM.

Parameters:
- s_offset, 5, byte-offset bits per line; line = 2**s_offset bytes.
- s_line, 8*2**s_offset (256), line width in bits.
- s_mem_index, 10, line-index bits of the backing store; depth = 2**s_mem_index lines.
- LATENCY, 4, cycles from request acceptance to mem_resp; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  line read request from the cache controller.
- mem_write  input  1  line write request from the cache controller.
- mem_address  input  32  byte address; bits [s_offset-1:0] are ignored.
- mem_byte_enable  input  4  accepted and ignored; every write is a full line.
- mem_wdata  input  s_line  write line data.
- mem_rdata  output  s_line  read line data.
- mem_resp  output  1  one-cycle completion pulse.
- protocol_err  output  1  one-cycle pulse when mem_read and mem_write are both high in IDLE.

Behaviour:
- Reset values: mem_resp=0, mem_rdata=0, protocol_err=0, state=IDLE, latency counter=0.
- Reset does not clear array contents. A reset arriving mid-transaction aborts it: no write commit, no mem_resp.
- Index = mem_address[s_offset +: s_mem_index]. Higher address bits alias (wrap) into the store.
- FSM states: IDLE, BUSY, RESP.
- IDLE, exactly one of mem_read/mem_write high:
  - Latch operation, index and mem_wdata.
  - Load counter with LATENCY-1.
  - Go to BUSY if LATENCY>1, otherwise go to RESP.
- IDLE, both requests high: no accept; pulse protocol_err next cycle; stay in IDLE.
- IDLE, neither request high: stay in IDLE.
- BUSY: decrement counter each cycle; go to RESP when the counter reaches 1. Request inputs are not sampled. A request that drops or changes mid-transaction still completes with the latched values.
- RESP:
  - mem_resp=1 for exactly this cycle.
  - Read: mem_rdata is the array line at the latched index, valid this cycle and held until the next read's RESP.
  - Write: array line is written at the end of this cycle; mem_rdata is unchanged.
  - Next state is always IDLE.
- Timing: a request seen in IDLE at cycle 0 gets mem_resp at cycle LATENCY.
- Minimum one IDLE cycle between transactions. With a Moore controller, a back-to-back request (write-back then fill) is accepted on the IDLE cycle after RESP.
- A read that follows a write to the same index returns the newly written data.

Optional Feature:
- Macro: MEM_STATS_EN.
- When defined:
  - Adds outputs rd_count[31:0] and wr_count[31:0], reset to 0.
  - Each counter increments by 1 in the cycle its operation's RESP occurs, wrapping modulo 2**32.
  - protocol_err events are not counted.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, LATENCY=4; write 0xA5 pattern line to address 0x0000_0040 -> mem_resp high exactly at cycle 4 after accept, single cycle; mem_rdata stays 0.
- Read 0x0000_005C after that write (same line, offset ignored) -> mem_resp at cycle 4; mem_rdata = 0xA5 pattern; held through 10 idle cycles.
- Write to 0x0000_0040 then read 0x0000_8040 with s_mem_index=10 (aliases index 2) -> read returns the written line.
- mem_read and mem_write both high in IDLE -> no mem_resp; protocol_err pulses 1 cycle; state remains IDLE.
- Assert rst at cycle 2 of a write with LATENCY=4 -> no mem_resp; subsequent read of that index returns prior contents.
- LATENCY=1: back-to-back write then read (Moore controller) -> resp at cycles 1 and 3. With MEM_STATS_EN: wr_count=1 and rd_count=1 afterwards.
